// File: rtl/surf_cin_scheduler_if.sv
// surf_cin_scheduler_if: valid/ready command request bus feeding the CIN scheduler.
interface surf_cin_scheduler_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    req_valid_i;
  logic [32*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]    req_ready_o;
  modport master (output req_valid_i, req_data_i, input req_ready_o);
  modport slave  (input req_valid_i, req_data_i, output req_ready_o);
endinterface

// File: rtl/surf_cin_scheduler.sv
// surf_cin_scheduler: arbitrates requesters onto one CIN command word per 8-cycle
// serializer frame and drives the serializer sync/train controls.
module surf_cin_scheduler #(
  parameter int          NREQ     = 3,
  parameter logic [31:0] IDLE_CMD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                 sysclk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 resync_i,
  input  logic                 train_req_i,
  surf_cin_scheduler_if.slave  req,
  output logic [31:0]          command_o,
  output logic                 train_o,
  output logic                 sync_o,
  output logic                 active_o,
  output logic [CNT_W-1:0]     cmd_count_o
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN, S_TRAIN} state_t;
  state_t            r_state;
  logic [2:0]        r_phase;
  logic [PW-1:0]     r_rr;
  logic [31:0]       r_cmd;
  logic              r_train, r_sync, r_active;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_hit, w_slot, w_arb;
  logic [PW-1:0]     w_idx, w_cand;
  logic [31:0]       w_data;
  // Scan descends so the candidate closest to r_rr is written last and wins.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    w_data = IDLE_CMD;
    for (int i = NREQ - 2; i >= 0; i--) begin
      w_cand = PW'((int'(r_rr) - 1 + i) % (NREQ - 1) + 1);
      if (req.req_valid_i[w_cand]) begin
        w_hit = 1'b1;
        w_idx = w_cand;
      end
    end
    if (req.req_valid_i[0]) begin
      w_hit = 1'b1;
      w_idx = '0;
    end
    for (int k = 0; k < NREQ; k++)
      if (w_idx == PW'(k)) w_data = req.req_data_i[32*k +: 32];
  end
  assign w_slot = (r_phase == 3'd6) && (r_state == S_RUN || r_state == S_TRAIN);
  assign w_arb  = w_slot && en_i && !resync_i && !train_req_i;
  assign req.req_ready_o = (w_arb && w_hit) ? (NREQ'(1) << w_idx) : '0;
  assign command_o   = r_cmd;
  assign train_o     = r_train;
  assign sync_o      = r_sync;
  assign active_o    = r_active;
  assign cmd_count_o = r_cnt;
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_phase  <= 3'd0;
      r_rr     <= PW'(1);
      r_cmd    <= IDLE_CMD;
      r_train  <= 1'b0;
      r_sync   <= 1'b0;
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_phase <= r_sync ? 3'd1 : r_phase + 3'd1;
      r_sync  <= 1'b0;
      case (r_state)
        S_IDLE: if (en_i) begin
          r_state <= S_SYNC;
          r_sync  <= 1'b1;
        end
        S_SYNC: begin
          r_state  <= train_req_i ? S_TRAIN : S_RUN;
          r_active <= 1'b1;
        end
        default: if (w_slot && !en_i) begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
          r_cmd    <= IDLE_CMD;
          r_train  <= 1'b0;
        end else if (en_i && resync_i) begin
          r_state  <= S_SYNC;
          r_sync   <= 1'b1;
          r_active <= 1'b0;
        end else if (w_slot && train_req_i) begin
          r_state <= S_TRAIN;
          r_train <= 1'b1;
          r_cmd   <= IDLE_CMD;
        end else if (w_slot) begin
          r_state <= S_RUN;
          r_train <= 1'b0;
          r_cmd   <= w_hit ? w_data : IDLE_CMD;
          if (w_hit) r_cnt <= r_cnt + CNT_W'(1);
          if (w_hit && w_idx != '0) r_rr <= (w_idx == PW'(NREQ - 1)) ? PW'(1) : w_idx + PW'(1);
        end
      endcase
    end
  end
endmodule

// File: doc/surf_cin_scheduler.md
Name: surf_cin_scheduler

Overview:
- Schedules the 32-bit command slot of the SURF command-input (CIN) link, i.e. the datapath from TURFIO to SURF.
- Arbitrates NREQ valid/ready command requesters onto one command word per 8-cycle frame.
- Generates the sync and train controls for the CIN serializer block, tracking the serializer's frame phase internally so every word is stable when the serializer samples it.
- Sits between run-control / trigger / register-access logic and the CIN serializer, all in sysclk.

Parameters:
- NREQ, 3, number of requesters (2..8); index 0 has fixed top priority.
- IDLE_CMD, 32'h00000000, word sent when no request is granted.
- CNT_W, 16, width of the issued-command counter.

Ports:
- sysclk_i  in  1  system clock; all logic in this domain.
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  level; enables scheduling.
- resync_i  in  1  pulse; forces a new sync and phase realignment.
- train_req_i  in  1  level; requests the training pattern.
- req_valid_i  in  NREQ  per-requester valid.
- req_data_i  in  32*NREQ  request words; requester k occupies bits [32k+31:32k].
- req_ready_o  out  NREQ  one-hot grant strobe; a transfer occurs when valid&&ready.
- command_o  out  32  to serializer command input.
- train_o  out  1  to serializer train input.
- sync_o  out  1  to serializer sync input; one-cycle pulse.
- active_o  out  1  high in RUN or TRAIN.
- cmd_count_o  out  CNT_W  count of granted (non-idle) commands.

Behaviour:
- Reset (rst_n_i low, asynchronous): state=IDLE, phase=0, rr_ptr=1, and all outputs 0. command_o resets to IDLE_CMD.
- Phase counter (3 bits) mirrors the serializer:
  - Loads 1 on the cycle after sync_o=1.
  - Otherwise increments mod 8.
  - The serializer samples command/train when its phase==7, so this block updates command_o and train_o only on the clock edge where phase==6. Both outputs are held constant for phases 7..5.
- States:
  - IDLE:
    - sync_o=0, train_o=0, command_o=IDLE_CMD, req_ready_o=0.
    - en_i=1 -> SYNC.
  - SYNC:
    - sync_o=1 for exactly one cycle; phase<=1.
    - Next state is TRAIN if train_req_i=1, else RUN.
  - RUN:
    - On the phase==6 cycle, evaluate arbitration combinationally from the current req_valid_i.
    - Grant index 0 if valid; else the first valid index at or after rr_ptr, scanning 1..NREQ-1 with wrap, skipping 0.
    - Winner k: req_ready_o[k]=1 for that single cycle; command_o<=req_data k; cmd_count_o+=1 (wraps modulo 2^CNT_W).
    - rr_ptr<=k+1 for k>=1 (wraps to 1 after NREQ-1); rr_ptr is unchanged on a grant to index 0.
    - No valid request: command_o<=IDLE_CMD, no ready, no count.
    - req_ready_o is 0 on all other phases. Requesters hold valid/data until ready.
    - train_req_i=1 sampled at phase 6 -> train_o<=1, command_o<=IDLE_CMD, no grant, next state TRAIN.
  - TRAIN:
    - No grants.
    - At phase 6, if train_req_i=0 -> train_o<=0 and state RUN. That same phase-6 cycle performs a normal arbitration.
- en_i=0 in RUN/TRAIN: return to IDLE at the next phase-6 edge, with command_o<=IDLE_CMD and train_o<=0. No grant that cycle.
- resync_i=1 in RUN/TRAIN: -> SYNC next cycle; train_o is preserved.
  - resync_i has priority over arbitration: if it coincides with phase 6, no grant, and command_o/train_o are unchanged.
  - resync_i in IDLE is ignored.
  - resync_i during SYNC is ignored.
- Simultaneous en_i=0 and resync_i: en_i=0 wins.
- Latency from grant to serializer load: phase-6 grant -> command_o valid at phase 7 -> serializer holds the word from the next edge.
- active_o is registered: 1 in RUN and TRAIN, 0 in IDLE and SYNC.

Test Plan:
- Reset then en_i=1: sync_o pulses exactly once, one cycle after en_i is sampled. Phase reads 1 the next cycle; command_o=0, active_o=1.
- Only req1 valid with data 32'hDEADBEEF: ready[1] pulses on the phase-6 cycle. command_o=DEADBEEF from phase 7 for 8 cycles; cmd_count_o=1.
- req0, req1 and req2 all continuously valid (NREQ=3): grant sequence over six frames is 0,0,0,0,0,0. Then drop req0: sequence alternates 1,2,1,2 with no gaps.
- train_req_i raised mid-frame at phase 3: train_o rises at phase 7 of the same frame and no ready is issued while high. Lowering it restores grants on the first phase-6 cycle afterwards.
- resync_i asserted exactly on a phase-6 cycle with req1 valid: no ready that cycle, sync_o pulses next cycle, and ready[1] appears 6 cycles after the sync pulse.
- rst_n_i dropped mid-RUN: all outputs go 0 asynchronously without a clock edge. With CNT_W=4, 17 grants produce cmd_count_o=1 (wrap).
